// File: rtl/ser160_tx.sv
// 4b/5b framing serializer: 16-bit words in via valid/ready, J K <nibbles> T packets out MSB first.
// Build option SER160_NRZI_EN selects NRZI line coding instead of plain NRZ.
module ser160_tx #(
  parameter int unsigned IDLE_MIN = 1
) (
  input  logic        clock_i,
  input  logic        res_i,
  input  logic        run_i,
  input  logic [15:0] data_i,
  input  logic        last_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        ser_out_o,
  output logic        busy_o,
  output logic        underrun_o,
  output logic [15:0] pkt_count_o
);

  localparam logic [4:0] SymI = 5'b11111;
  localparam logic [4:0] SymJ = 5'b11000;
  localparam logic [4:0] SymK = 5'b10001;
  localparam logic [4:0] SymT = 5'b01101;
  localparam logic [3:0] IdleMinC = 4'(IDLE_MIN);

  typedef enum logic [1:0] {StIdle, StSop, StData, StEop} state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  nib_cnt_q, nib_cnt_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic        sop_k_q, sop_k_d;
  logic [15:0] word_q, word_d;
  logic        last_q, last_d;
  logic        ser_q, ser_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;
  logic [15:0] pkt_count_q, pkt_count_d;

  logic        boundary;
  logic        accept;
  logic [3:0]  nibble;
  logic [4:0]  sym;
  logic        sym_bit;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    logic [4:0] s;
    unique case (n)
      4'h0: s = 5'b11110;
      4'h1: s = 5'b01001;
      4'h2: s = 5'b10100;
      4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;
      4'h5: s = 5'b01011;
      4'h6: s = 5'b01110;
      4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;
      4'h9: s = 5'b10011;
      4'hA: s = 5'b10110;
      4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;
      4'hD: s = 5'b11011;
      4'hE: s = 5'b11100;
      4'hF: s = 5'b11101;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock_i) begin
    if (res_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      nib_cnt_q   <= 2'd0;
      idle_cnt_q  <= 4'd0;
      sop_k_q     <= 1'b0;
      word_q      <= 16'd0;
      last_q      <= 1'b0;
      ser_q       <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      nib_cnt_q   <= nib_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      sop_k_q     <= sop_k_d;
      word_q      <= word_d;
      last_q      <= last_d;
      ser_q       <= ser_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Output / symbol decode for the current state.
  always_comb begin
    boundary = (bit_cnt_q == 3'd4);
    unique case (nib_cnt_q)
      2'd0: nibble = word_q[15:12];
      2'd1: nibble = word_q[11:8];
      2'd2: nibble = word_q[7:4];
      2'd3: nibble = word_q[3:0];
    endcase
    unique case (state_q)
      StIdle: sym = SymI;
      StSop:  sym = sop_k_q ? SymK : SymJ;
      StData: sym = enc4b5b(nibble);
      StEop:  sym = SymT;
    endcase
    sym_bit = sym[3'd4 - bit_cnt_q];
    ready_o = boundary &&
              (((state_q == StIdle) && run_i && (idle_cnt_q == IdleMinC)) ||
               ((state_q == StData) && (nib_cnt_q == 2'd3) && !last_q));
    accept  = ready_o && valid_i;
  end

  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    sop_k_d     = sop_k_q;
    word_d      = word_q;
    last_d      = last_q;
    underrun_d  = underrun_q;
    pkt_count_d = pkt_count_q;
    bit_cnt_d   = boundary ? 3'd0 : bit_cnt_q + 3'd1;
`ifdef SER160_NRZI_EN
    ser_d       = ser_q ^ sym_bit;
`else
    ser_d       = sym_bit;
`endif
    // Registered busy follows the bit being driven onto ser_out this edge.
    busy_d      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        // Count each idle symbol as it starts so ready opens at its end.
        if ((bit_cnt_q == 3'd0) && (idle_cnt_q != IdleMinC)) idle_cnt_d = idle_cnt_q + 4'd1;
        if (accept) begin
          word_d  = data_i;
          last_d  = last_i;
          sop_k_d = 1'b0;
          state_d = StSop;
        end
      end
      StSop: begin
        if (boundary) begin
          if (sop_k_q) begin
            state_d   = StData;
            nib_cnt_d = 2'd0;
          end else begin
            sop_k_d = 1'b1;
          end
        end
      end
      StData: begin
        if (boundary) begin
          if (nib_cnt_q != 2'd3) begin
            nib_cnt_d = nib_cnt_q + 2'd1;
          end else if (last_q) begin
            state_d = StEop;
          end else if (valid_i) begin
            word_d    = data_i;
            last_d    = last_i;
            nib_cnt_d = 2'd0;
          end else begin
            state_d    = StEop;
            underrun_d = 1'b1;
          end
        end
      end
      StEop: begin
        if (boundary) begin
          state_d     = StIdle;
          idle_cnt_d  = 4'd0;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
    endcase
  end

  assign ser_out_o   = ser_q;
  assign busy_o      = busy_q;
  assign underrun_o  = underrun_q;
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_ser160_tx.sv
// Bench for ser160_tx: packet bit streams checked against a symbol-level model.
// Works for both the NRZ build and the SER160_NRZI_EN build (line is decoded before comparing).
module tb_ser160_tx;

  logic        clk = 1'b0;
  logic        res, run, last, valid;
  logic [15:0] data;
  logic        ready, ser_out, busy, underrun;
  logic [15:0] pkt_count;
  logic        res3 = 1'b1;
  logic        ready3, ser3, busy3, und3;
  logic [15:0] cnt3;

  always #5 clk = ~clk;

  ser160_tx #(.IDLE_MIN(1)) dut (
    .clock_i(clk), .res_i(res), .run_i(run), .data_i(data), .last_i(last), .valid_i(valid),
    .ready_o(ready), .ser_out_o(ser_out), .busy_o(busy), .underrun_o(underrun),
    .pkt_count_o(pkt_count)
  );

  ser160_tx #(.IDLE_MIN(3)) dut3 (
    .clock_i(clk), .res_i(res3), .run_i(1'b1), .data_i(16'h0000), .last_i(1'b0),
    .valid_i(1'b0), .ready_o(ready3), .ser_out_o(ser3), .busy_o(busy3), .underrun_o(und3),
    .pkt_count_o(cnt3)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0] enc_tab [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                               5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                               5'b11010, 5'b11011, 5'b11100, 5'b11101};
  logic [4:0] sym_j = 5'b11000;
  logic [4:0] sym_k = 5'b10001;
  logic [4:0] sym_t = 5'b01101;

  int          exp_pkts = 0;
  logic        exp_und = 1'b0;
  logic        prev_line;
  logic        bits[$];
  logic        busys[$];
  int          accs[$];
  logic        exp_q[$];
  logic [15:0] wq[$];
  logic        lq[$];

  function automatic logic decode(input logic line);
`ifdef SER160_NRZI_EN
    return line ^ prev_line;
`else
    return line;
`endif
  endfunction

  task automatic push_sym(input logic [4:0] s);
    for (int b = 4; b >= 0; b--) exp_q.push_back(s[b]);
  endtask

  // Packet model: J K, four symbols per accepted word, T; ends on last or when words run out.
  task automatic build_expect(output int nacc, output logic und, output int plen);
    logic [15:0] w;
    exp_q.delete();
    nacc = 0;
    und  = 1'b0;
    push_sym(sym_j);
    push_sym(sym_k);
    for (int i = 0; i < wq.size(); i++) begin
      nacc++;
      w = wq[i];
      for (int n = 3; n >= 0; n--) push_sym(enc_tab[(w >> (4 * n)) & 16'hF]);
      if (lq[i]) break;
      if (i == wq.size() - 1) und = 1'b1;
    end
    push_sym(sym_t);
    plen = exp_q.size();
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
  endtask

  function automatic int stream_errs(input int a);
    int e = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (a + i < 0 || a + i >= bits.size()) e++;
      else if (bits[a + i] !== exp_q[i]) e++;
    end
    return e;
  endfunction

  function automatic int busy_errs(input int a, input int len);
    int e = 0;
    for (int i = 0; i < busys.size(); i++)
      if (busys[i] !== ((i >= a) && (i < a + len))) e++;
    return e;
  endfunction

  // Streams wq/lq with valid held high; records decoded line, busy and accept cycles.
  task automatic run_stream(input int ncyc, input bit drop_run);
    int k = 0;
    bit pend = 1'b0;
    bits.delete();
    busys.delete();
    accs.delete();
    prev_line = ser_out;
    valid = 1'b1;
    data  = wq[0];
    last  = lq[0];
    #1;
    if (valid && ready) begin
      pend = 1'b1;
      accs.push_back(-1);
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #2;
      bits.push_back(decode(ser_out));
      prev_line = ser_out;
      busys.push_back(busy);
      if (pend) begin
        pend = 1'b0;
        k++;
        if (drop_run) run = 1'b0;
        if (k < wq.size()) begin
          data = wq[k];
          last = lq[k];
        end else begin
          valid = 1'b0;
        end
      end
      #1;
      if (valid && ready) begin
        pend = 1'b1;
        accs.push_back(c);
      end
    end
    valid = 1'b0;
    run   = 1'b1;
  endtask

  task automatic test_reset;
    int e_bit = 0, e_rdy = 0, e_busy = 0;
    logic b;
    res = 1'b1; run = 1'b1; valid = 1'b0; data = 16'h0; last = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      checks++;
      if ({ready, ser_out, busy, underrun, pkt_count} !== 20'd0)
        $display("FAIL reset_outputs: got %b expected all zero",
                 {ready, ser_out, busy, underrun, pkt_count});
    end
    res = 1'b0;
    prev_line = ser_out;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #2;
      b = decode(ser_out);
      prev_line = ser_out;
      if (b !== 1'b1) e_bit++;
      if (ready !== ((k % 5) == 3)) e_rdy++;
      if (busy !== 1'b0) e_busy++;
    end
    checks += 3;
    if (e_bit != 0) begin errors++; $display("FAIL idle_line: %0d bad bits, expected 0", e_bit); end
    if (e_rdy != 0) begin errors++; $display("FAIL idle_ready: %0d bad, expected 0", e_rdy); end
    if (e_busy != 0) begin errors++; $display("FAIL idle_busy: %0d bad, expected 0", e_busy); end
  endtask

  task automatic test_single;
    logic [34:0] lit = 35'b11000_10001_01001_10100_10101_01010_01101;
    int nacc, plen, e = 0, a;
    logic und;
    wq = '{16'h1234};
    lq = '{1'b1};
    build_expect(nacc, und, plen);
    run_stream(plen + 25, 1'b0);
    exp_pkts++;
    checks++;
    if (accs.size() !== 1) begin
      errors++;
      $display("FAIL single_accepts: got %0d expected 1", accs.size());
    end else begin
      a = accs[0] + 2;
      for (int i = 0; i < 35; i++) if (a + i >= bits.size() || bits[a + i] !== lit[34 - i]) e++;
      if (a + 35 >= bits.size() || bits[a + 35] !== 1'b1) e++;
      checks += 2;
      if (e != 0) begin errors++; $display("FAIL single_bits: %0d wrong, expected 0", e); end
      e = busy_errs(a, 35);
      if (e != 0) begin errors++; $display("FAIL single_busy: %0d wrong, expected 0", e); end
    end
    checks += 2;
    if (pkt_count !== 16'(exp_pkts)) begin
      errors++; $display("FAIL single_pkt_count: got %0d expected %0d", pkt_count, exp_pkts);
    end
    if (underrun !== exp_und) begin
      errors++; $display("FAIL single_underrun: got %b expected %b", underrun, exp_und);
    end
  endtask

  task automatic test_two_word;
    int nacc, plen, e, a;
    logic und;
    wq = '{16'hABCD, 16'h0F00};
    lq = '{1'b0, 1'b1};
    build_expect(nacc, und, plen);
    run_stream(plen + 25, 1'b0);
    exp_pkts++;
    checks++;
    if (accs.size() !== nacc) begin
      errors++;
      $display("FAIL two_accepts: got %0d expected %0d", accs.size(), nacc);
    end else begin
      a = accs[0] + 2;
      checks += 3;
      e = stream_errs(a);
      if (e != 0) begin errors++; $display("FAIL two_bits: %0d wrong, expected 0", e); end
      if (accs[1] - accs[0] !== 30) begin
        errors++; $display("FAIL two_ready_gap: got %0d expected 30", accs[1] - accs[0]);
      end
      e = busy_errs(a, plen);
      if (e != 0) begin errors++; $display("FAIL two_busy: %0d wrong, expected 0", e); end
    end
    checks++;
    if (pkt_count !== 16'(exp_pkts)) begin
      errors++; $display("FAIL two_pkt_count: got %0d expected %0d", pkt_count, exp_pkts);
    end
  endtask

  task automatic test_run_gate;
    int hits = 0;
    run = 1'b0; valid = 1'b1; data = 16'hBEEF; last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #3;
      if (ready !== 1'b0 || busy !== 1'b0) hits++;
    end
    valid = 1'b0;
    run = 1'b1;
    checks++;
    if (hits != 0) begin errors++; $display("FAIL run_gate: %0d active cycles, expected 0", hits); end
  endtask

  task automatic test_underrun;
    int nacc, plen, e;
    logic und;
    wq = '{16'h5555};
    lq = '{1'b0};
    build_expect(nacc, und, plen);
    run_stream(plen + 25, 1'b0);
    exp_pkts++;
    exp_und = exp_und | und;
    checks += 3;
    e = (accs.size() == 1) ? stream_errs(accs[0] + 2) : 999;
    if (e != 0) begin errors++; $display("FAIL underrun_bits: %0d wrong, expected 0", e); end
    if (underrun !== exp_und) begin
      errors++; $display("FAIL underrun_flag: got %b expected %b", underrun, exp_und);
    end
    if (pkt_count !== 16'(exp_pkts)) begin
      errors++; $display("FAIL underrun_pkt_count: got %0d expected %0d", pkt_count, exp_pkts);
    end
  endtask

  task automatic test_random;
    int nacc, plen, e, n;
    logic und;
    for (int p = 0; p < 5; p++) begin
      wq.delete();
      lq.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        wq.push_back(16'($urandom));
        lq.push_back((i == n - 1) ? ($urandom_range(0, 3) != 0) : 1'b0);
      end
      build_expect(nacc, und, plen);
      run_stream(plen + 25, $urandom_range(0, 1) == 1);
      exp_pkts++;
      exp_und = exp_und | und;
      e = 0;
      if (accs.size() !== nacc) e = 999;
      else begin
        e = stream_errs(accs[0] + 2) + busy_errs(accs[0] + 2, plen);
        for (int k = 1; k < nacc; k++) if (accs[k] - accs[0] != 10 + 20 * k) e++;
      end
      checks += 3;
      if (e != 0) begin errors++; $display("FAIL random_pkt%0d: %0d wrong, expected 0", p, e); end
      if (pkt_count !== 16'(exp_pkts)) begin
        errors++; $display("FAIL random_pkt_count: got %0d expected %0d", pkt_count, exp_pkts);
      end
      if (underrun !== exp_und) begin
        errors++; $display("FAIL random_underrun: got %b expected %b", underrun, exp_und);
      end
    end
  endtask

  task automatic test_idle_min3;
    int first = -1;
    @(posedge clk);
    #3;
    res3 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (ready3 === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first !== 13) begin
      errors++; $display("FAIL idle_min3_first_ready: got cycle %0d expected 13", first);
    end
  endtask

  task automatic test_abort;
    bit got = 1'b0;
    int e = 0;
    logic b;
    res = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    res = 1'b0;
    data = 16'h1234; last = 1'b1; valid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #3;
      if (ready) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL abort_ready: got no ready expected one"); end
    @(posedge clk);
    #2;
    valid = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b expected 1", busy); end
    res = 1'b1;
    @(posedge clk);
    #2;
    checks += 2;
    if ({ready, ser_out, busy, underrun} !== 4'd0) begin
      errors++; $display("FAIL abort_outputs: got %b expected 0000", {ready, ser_out, busy, underrun});
    end
    if (pkt_count !== 16'd0) begin
      errors++; $display("FAIL abort_pkt_count: got %0d expected 0", pkt_count);
    end
    res = 1'b0;
    prev_line = ser_out;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #2;
      b = decode(ser_out);
      prev_line = ser_out;
      if (b !== 1'b1 || busy !== 1'b0 || pkt_count !== 16'd0) e++;
    end
    checks++;
    if (e != 0) begin errors++; $display("FAIL abort_no_tail: %0d bad cycles, expected 0", e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_word();
    test_run_gate();
    test_underrun();
    test_random();
    test_idle_min3();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
